// File: rtl/mme_apb_master.sv
// Single-outstanding APB master: one request in, one APB transfer, one response out.
// Optional ACCESS-phase timeout is compiled in with `define MME_APB_TIMEOUT_EN.
module mme_apb_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  // state  | meaning
  // IDLE   | waiting for a request (req_ready high once out of reset)
  // SETUP  | APB setup phase, psel=1 penable=0, one cycle
  // ACCESS | APB access phase, waiting for pready (or timeout)
  // RESP   | response held on rsp_* until rsp_ready
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t            state, state_nxt;
  logic              live;
  logic              accept;
  logic              done;
  logic              abort;
  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  assign accept    = (state == IDLE) && live && req_valid;
  assign done      = (state == ACCESS) && (pready || abort);
  assign paddr     = addr_q;
  assign pwrite    = write_q;
  assign pwdata    = wdata_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

`ifdef MME_APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;

  // SETUP always precedes ACCESS, so clearing here clears on ACCESS entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state == SETUP) begin
      wait_cnt <= '0;
    end else if ((state == ACCESS) && !pready) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign abort = (state == ACCESS) && !pready &&
                 (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic timeout_unused;
  assign timeout_unused = (TIMEOUT_CYCLES > 0);
  assign abort          = 1'b0;
`endif

  // live holds req_ready low for the whole time reset is asserted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      live  <= 1'b0;
    end else begin
      state <= state_nxt;
      live  <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    psel      = 1'b0;
    penable   = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = live;
        if (accept) state_nxt = SETUP;
      end
      SETUP: begin
        psel      = 1'b1;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (pready || abort) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= req_addr;
        write_q <= req_write;
        wdata_q <= req_wdata;
      end
      if (done) begin
        // a timeout ends with pready low, which reports as an error
        err_q   <= pready ? pslverr : 1'b1;
        rdata_q <= (pready && !write_q && !pslverr) ? prdata : '0;
      end else if ((state == RESP) && rsp_ready) begin
        err_q   <= 1'b0;
        rdata_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mme_apb_master.sv
// Bench for mme_apb_master: vector table driven through a reactive APB completer,
// responses checked against a scoreboard queue, plus reset and timeout sequences.
module tb_mme_apb_master;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;
`ifdef MME_APB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] paddr;
  logic          psel, penable, pwrite;
  logic [DW-1:0] pwdata, prdata;
  logic          pready, pslverr;

  mme_apb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic        err;
    int          waits;
    int          hold;
    logic        busy;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[6];

  task automatic drive_req(input vec_t v, input bit push);
    exp_t e;
    req_valid = 1'b1;
    req_write = v.wr;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    check("req_ready_idle", req_ready, 1'b1);
    e.rdata = v.exp_rdata;
    e.err   = v.exp_err;
    e.due   = (TO_EN && v.waits >= TO) ? cyc + 2 + TO : cyc + 3 + v.waits;
    if (push) sb.push_back(e);
    @(posedge clk); #1;
    if (v.busy) begin
      req_addr  = v.addr ^ 32'h0000_0FFF;
      req_write = ~v.wr;
      req_wdata = ~v.wdata;
    end else begin
      req_valid = 1'b0;
    end
    check("setup_phase", {psel, penable}, 2'b10);
  endtask

  task automatic finish_xfer(input vec_t v);
    int   acc = 0;
    bit   got = 0;
    bit   stable_ok = 1;
    bit   hold_ok = 1;
    int   exp_acc;
    logic [31:0] r;
    logic        e;
    exp_t x;
    exp_acc = (TO_EN && v.waits >= TO) ? TO : v.waits + 1;
    for (int c = 0; c < 200 && !got; c++) begin
      if (rsp_valid) begin
        got = 1;
      end else begin
        if (psel && (paddr !== v.addr || pwrite !== v.wr || pwdata !== v.wdata)) stable_ok = 0;
        if (psel && penable) begin
          pready  = (acc == v.waits);
          pslverr = (acc == v.waits) ? v.err : 1'b1;
          prdata  = (acc == v.waits) ? v.rd : 32'hBAD0_0000 + acc;
          acc++;
        end else begin
          pready  = 1'b0;
          pslverr = 1'b0;
          prdata  = 32'h0;
        end
        @(posedge clk); #1;
      end
    end
    // completer noise outside ACCESS must not disturb the held response
    pready  = 1'b1;
    pslverr = 1'b1;
    prdata  = 32'hFFFF_FFFF;
    check("rsp_arrived", got, 1'b1);
    check("penable_cycles", acc, exp_acc);
    check("apb_stable", stable_ok, 1'b1);
    check("latency", cyc, (sb.size() > 0) ? sb[0].due : -1);
    r = rsp_rdata;
    e = rsp_err;
    for (int h = 0; h < v.hold; h++) begin
      if (!rsp_valid || rsp_rdata !== r || rsp_err !== e || req_ready || psel || penable)
        hold_ok = 0;
      @(posedge clk); #1;
    end
    if (v.hold > 0) check("hold_stable", hold_ok, 1'b1);
    rsp_ready = 1'b1;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      check("rsp_rdata", rsp_rdata, x.rdata);
      check("rsp_err", rsp_err, x.err);
    end else begin
      check("sb_nonempty", 1'b0, 1'b1);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    pready    = 1'b0;
    pslverr   = 1'b0;
    prdata    = 32'h0;
    check("back_idle", {req_ready, psel, rsp_valid}, 3'b100);
  endtask

  initial begin
    vec_t v;
    int   pe;
    bit   seen;

    vecs[0] = '{1'b1, 32'h100, 32'h0000_0008, 32'h7777_7777, 1'b0, 0, 0, 1'b0, 32'h0, 1'b0};
    vecs[1] = '{1'b0, 32'h000, 32'h0, 32'h0001_0203, 1'b0, 3, 0, 1'b0, 32'h0001_0203, 1'b0};
    vecs[2] = '{1'b0, 32'h210, 32'h0, 32'h55AA_55AA, 1'b1, 1, 0, 1'b1, 32'h0, 1'b1};
    vecs[3] = '{1'b0, 32'h044, 32'h0, 32'hCAFE_F00D, 1'b0, 0, 5, 1'b1, 32'hCAFE_F00D, 1'b0};
    vecs[4] = '{1'b1, 32'h208, 32'hA5A5_0001, 32'h0, 1'b1, 2, 0, 1'b0, 32'h0, 1'b1};
    vecs[5] = '{1'b1, 32'h3FC, 32'h1234_5678, 32'h1234_5678, 1'b0, 1, 2, 1'b0, 32'h0, 1'b0};

    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
    #2;
    check("reset_outputs",
          {req_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite},
          {1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0});
    check("reset_paddr_pwdata", {paddr, pwdata}, 64'h0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_reset", req_ready, 1'b1);

    for (int i = 0; i < 6; i++) begin
      drive_req(vecs[i], 1'b1);
      finish_xfer(vecs[i]);
    end

    // reset pulse in the middle of a stalled ACCESS phase
    v = '{1'b0, 32'h080, 32'h0, 32'h1111_2222, 1'b0, 50, 0, 1'b0, 32'h0, 1'b0};
    drive_req(v, 1'b0);
    pe = 0;
    for (int c = 0; c < 10 && pe < 2; c++) begin
      if (penable) pe++;
      pready = 1'b0;
      @(posedge clk); #1;
    end
    check("reached_access", pe, 2);
    #3 rst_n = 1'b0;
    #1;
    check("rst_drop_apb", {psel, penable, rsp_valid, req_ready}, 4'b0000);
    @(posedge clk); #1;
    check("rst_held", {psel, penable, rsp_valid, req_ready}, 4'b0000);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_release", {req_ready, psel, rsp_valid}, 3'b100);
    drive_req(vecs[0], 1'b1);
    finish_xfer(vecs[0]);

    // completer that never answers
    v = '{1'b0, 32'h300, 32'h0, 32'h9999_9999, 1'b0, 100000, 0, 1'b0, 32'h0, 1'b1};
    if (TO_EN) begin
      drive_req(v, 1'b1);
      finish_xfer(v);
    end else begin
      drive_req(v, 1'b0);
      seen = 0;
      for (int c = 0; c < 1000; c++) begin
        if (rsp_valid) seen = 1;
        pready = 1'b0;
        @(posedge clk); #1;
      end
      check("no_timeout_rsp", seen, 1'b0);
      check("still_access", {psel, penable}, 2'b11);
      #3 rst_n = 1'b0;
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      check("recover_idle", req_ready, 1'b1);
    end

    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mme_apb_master.md
MME_APB_MASTER -- requirements
Module: mme_apb_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, APB/request address width.
REQ-002 SHALL have parameter DATA_W, default 32, APB/request data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 256, maximum ACCESS-phase wait; used only when the timeout feature is compiled in.
REQ-004 SHALL use one clock and an asynchronous, active-low reset, with ports as follows.
- clk  input  1  sole clock.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  request accepted when high with req_valid.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_W  register byte address.
- req_wdata  input  DATA_W  write data.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  response consumed when high with rsp_valid.
- rsp_rdata  output  DATA_W  read data; 0 for writes and errors.
- rsp_err  output  1  transfer ended with pslverr or timeout.
- paddr  output  ADDR_W  APB address.
- psel  output  1  APB select.
- penable  output  1  APB enable.
- pwrite  output  1  APB direction.
- pwdata  output  DATA_W  APB write data.
- prdata  input  DATA_W  APB read data.
- pready  input  1  APB completer ready.
- pslverr  input  1  APB completer error.

Function
REQ-005 SHALL implement the FSM states IDLE, SETUP, ACCESS and RESP, with exactly one transfer in flight.
REQ-006 SHALL drive req_ready=1 only in IDLE; on req_valid&&req_ready it SHALL latch req_write, req_addr and req_wdata and enter SETUP next cycle.
REQ-007 SHALL, in SETUP, drive psel=1 and penable=0 for exactly one cycle, then enter ACCESS.
REQ-008 SHALL, in ACCESS, drive psel=1 and penable=1 until pready=1 is sampled.
REQ-009 SHALL hold paddr, pwrite and pwdata stable from SETUP through the final ACCESS cycle.
REQ-010 SHALL, on the pready=1 cycle, capture prdata (reads only) and pslverr, then enter RESP. rsp_rdata SHALL be 0 for writes, and SHALL be 0 when pslverr=1.
REQ-011 SHALL drive psel=0 and penable=0 in IDLE and RESP.
REQ-012 SHALL assert rsp_valid in RESP and hold rsp_valid, rsp_rdata and rsp_err stable until rsp_ready=1. It SHALL then return to IDLE, where req_ready=1 in the next cycle.
REQ-013 SHALL achieve a minimum latency from accept cycle T of rsp_valid at T+3 (pready=1 on the first ACCESS cycle); each pready=0 cycle adds one.
REQ-014 SHALL ignore prdata, pready and pslverr outside ACCESS.
REQ-015 SHALL ignore req_valid outside IDLE, with no queuing.

Reset
REQ-016 SHALL, on rst_n=0, immediately (asynchronously) force state IDLE, all outputs 0 (req_ready=0 while in reset), and the timeout counter 0.
REQ-017 SHALL, on reset asserted mid-transfer, drop psel/penable the same instant and discard the transfer with no response issued; req_ready=1 on the first clock after release.

Configuration
REQ-018 SHALL, with macro MME_APB_TIMEOUT_EN defined, count ACCESS cycles with pready=0. On reaching TIMEOUT_CYCLES it SHALL abort: psel=penable=0, enter RESP with rsp_err=1, rsp_rdata=0. The counter SHALL clear on entering ACCESS.
REQ-019 SHALL, without MME_APB_TIMEOUT_EN, contain no counter logic and wait in ACCESS indefinitely; the port list SHALL be identical in both builds.

Verification
REQ-020 SHALL cover write 0x100<-0x00000008 with pready=1 immediately: psel rises at T+1, penable at T+2, rsp_valid at T+3 with rsp_err=0, rsp_rdata=0.
REQ-021 SHALL cover read 0x000 with prdata=0x00010203 and 3 pready=0 wait cycles: penable high 4 cycles, rsp_rdata=0x00010203, rsp_valid at T+6.
REQ-022 SHALL cover read 0x210 with pslverr=1: rsp_err=1, rsp_rdata=0, FSM returns to IDLE.
REQ-023 SHALL cover rsp_ready held low 5 cycles: rsp_valid and rsp_rdata stable, req_ready=0, psel=0 throughout.
REQ-024 SHALL cover rst_n pulsed low during ACCESS: psel/penable 0 immediately, no rsp_valid, next request completes normally.
REQ-025 SHALL cover, with MME_APB_TIMEOUT_EN and TIMEOUT_CYCLES=16, pready held 0: abort after 16 ACCESS cycles, rsp_err=1; without the macro, no response after 1000 cycles.
